// File: rtl/bcedn_input_streamer.sv
// Frame replay streamer feeding the BCEDN adapter: a small FIFO that issues one H*W*D frame per start.
// Optional macro BCEDN_STREAM_STATS_EN adds saturating stall/starve counters as outputs.
module bcedn_input_streamer #(
  parameter int DATA_W       = 8,
  parameter int H            = 32,
  parameter int W            = 32,
  parameter int D            = 3,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     wr_en,
  input  logic signed [DATA_W-1:0] wr_data,
  output logic                     wr_full,
  output logic                     wr_afull,
  input  logic                     pad_stall,
  output logic                     in_en,
  output logic signed [DATA_W-1:0] data_in,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overflow
`ifdef BCEDN_STREAM_STATS_EN
  ,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              starve_cnt
`endif
);

  localparam int FRAME  = H * W * D;
  localparam int PCNT_W = $clog2(FRAME + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  MARGIN_C = CNT_W'(AFULL_MARGIN);
  localparam logic [PCNT_W-1:0] LAST_PIX = PCNT_W'(FRAME - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  logic signed [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic [PCNT_W-1:0]        pix_cnt;
  state_t                   state;

  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic                     vld_p1;
  logic signed [DATA_W-1:0] data_p1;

  // Flags derive from the registered count only, so a same-cycle pop never frees a slot for a write.
  assign fifo_empty = (count == '0);
  assign wr_full    = (count == DEPTH_C);
  assign wr_afull   = ((DEPTH_C - count) <= MARGIN_C);
  assign push       = wr_en && !wr_full;
  assign pop        = (state == STREAM) && !fifo_empty && !pad_stall;

  assign in_en   = vld_p1;
  assign data_in = data_p1;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Stage p0 -> p1: pop decision and head word registered onto the adapter interface.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pix_cnt    <= '0;
      state      <= IDLE;
      vld_p1     <= 1'b0;
      data_p1    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      vld_p1     <= pop;
      data_p1    <= pop ? mem[rd_ptr] : '0;
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state    <= STREAM;
            pix_cnt  <= '0;
            busy     <= 1'b1;
            overflow <= 1'b0;
          end
        end
        STREAM: begin
          if (pop) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (pix_cnt == LAST_PIX) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A rejected write is recorded even in the cycle a new frame starts.
      if (wr_en && wr_full) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef BCEDN_STREAM_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt  <= '0;
      starve_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cnt  <= '0;
      starve_cnt <= '0;
    end else if (state == STREAM) begin
      if (fifo_empty) begin
        starve_cnt <= sat_inc(starve_cnt);
      end else if (pad_stall) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bcedn_input_streamer.sv
// Directed self-checking bench for bcedn_input_streamer with a 4x4x1 frame and a 16-entry FIFO.
module tb_bcedn_input_streamer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       wr_en = 1'b0;
  logic       pad_stall = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_full, wr_afull, in_en, busy, frame_done, overflow;
  logic [7:0] data_in;
`ifdef BCEDN_STREAM_STATS_EN
  logic [15:0] stall_cnt, starve_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcedn_input_streamer #(
    .DATA_W(8), .H(4), .W(4), .D(1), .FIFO_DEPTH(16), .AFULL_MARGIN(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(wr_full), .wr_afull(wr_afull), .pad_stall(pad_stall),
    .in_en(in_en), .data_in(data_in), .busy(busy), .frame_done(frame_done),
    .overflow(overflow)
`ifdef BCEDN_STREAM_STATS_EN
    , .stall_cnt(stall_cnt), .starve_cnt(starve_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; start = 1'b0; wr_en = 1'b0; pad_stall = 1'b0; wr_data = 8'h00;
    tick; tick;
    rst = 1'b1;
  endtask

  task automatic prefill(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_data = 8'(base + i);
      tick;
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({in_en, busy, frame_done, overflow, wr_full, wr_afull} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000000", {in_en, busy, frame_done, overflow, wr_full, wr_afull});
    end
    checks++;
    if (data_in !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h required 00", data_in);
    end
`ifdef BCEDN_STREAM_STATS_EN
    checks++;
    if (stall_cnt !== 16'd0 || starve_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_stats: got %0d/%0d required 0/0", stall_cnt, starve_cnt);
    end
`endif
  endtask

  task automatic test_basic;
    do_reset;
    prefill(16, 1);
    checks++;
    if (wr_full !== 1'b1) begin
      errors++; $display("FAIL basic_full: got %b required 1", wr_full);
    end
    pulse_start;
    checks++;
    if (busy !== 1'b1 || in_en !== 1'b0) begin
      errors++; $display("FAIL basic_start: got busy=%b in_en=%b required busy=1 in_en=0", busy, in_en);
    end
    for (int k = 0; k < 16; k++) begin
      tick;
      checks++;
      if (in_en !== 1'b1 || data_in !== 8'(k + 1)) begin
        errors++; $display("FAIL basic_word%0d: got en=%b data=%h required en=1 data=%h", k, in_en, data_in, 8'(k + 1));
      end
    end
    tick;
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || in_en !== 1'b0) begin
      errors++; $display("FAIL basic_done: got fd=%b busy=%b en=%b required fd=1 busy=0 en=0", frame_done, busy, in_en);
    end
    tick;
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: got %b required 0", frame_done);
    end
  endtask

  task automatic test_pad_stall;
    int  nxt;
    logic exp_en;
    nxt = 1;
    do_reset;
    prefill(16, 1);
    pulse_start;
    for (int k = 0; k < 19; k++) begin
      pad_stall = (k >= 5 && k <= 7);
      tick;
      exp_en = !(k >= 5 && k <= 7);
      checks++;
      if (in_en !== exp_en || (exp_en && data_in !== 8'(nxt))) begin
        errors++; $display("FAIL stall_cycle%0d: got en=%b data=%h required en=%b data=%h", k, in_en, data_in, exp_en, 8'(nxt));
      end
      if (exp_en) nxt++;
    end
    pad_stall = 1'b0;
    tick;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("FAIL stall_done: got %b required 1", frame_done);
    end
`ifdef BCEDN_STREAM_STATS_EN
    checks++;
    if (stall_cnt !== 16'd3 || starve_cnt !== 16'd0) begin
      errors++; $display("FAIL stall_stats: got stall=%0d starve=%0d required 3/0", stall_cnt, starve_cnt);
    end
`endif
  endtask

  task automatic test_overflow;
    int exp_cnt;
    do_reset;
    for (int i = 1; i <= 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick;
      exp_cnt = (i < 16) ? i : 16;
      checks++;
      if (wr_full !== (exp_cnt == 16) || wr_afull !== (exp_cnt >= 14) || overflow !== (i == 17)) begin
        errors++;
        $display("FAIL ovf_write%0d: got full=%b afull=%b ovf=%b required %b %b %b", i, wr_full, wr_afull, overflow,
                 exp_cnt == 16, exp_cnt >= 14, i == 17);
      end
    end
    wr_en = 1'b0;
    pulse_start;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b required 0", overflow);
    end
    for (int k = 0; k < 16; k++) begin
      tick;
      checks++;
      if (in_en !== 1'b1 || data_in !== 8'(k + 1)) begin
        errors++; $display("FAIL ovf_word%0d: got en=%b data=%h required en=1 data=%h", k, in_en, data_in, 8'(k + 1));
      end
    end
    tick;
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("FAIL ovf_done: got %b required 1", frame_done);
    end
  endtask

  task automatic test_starve;
    do_reset;
    pulse_start;
    for (int j = 0; j < 16; j++) begin
      wr_en = 1'b1; wr_data = 8'(8'hA0 + j);
      tick;
      wr_en = 1'b0;
      checks++;
      if (in_en !== 1'b0) begin
        errors++; $display("FAIL starve_nobypass%0d: got %b required 0", j, in_en);
      end
      tick;
      checks++;
      if (in_en !== 1'b1 || data_in !== 8'(8'hA0 + j)) begin
        errors++; $display("FAIL starve_word%0d: got en=%b data=%h required en=1 data=%h", j, in_en, data_in, 8'(8'hA0 + j));
      end
      tick;
      checks++;
      if (in_en !== 1'b0 || frame_done !== (j == 15)) begin
        errors++; $display("FAIL starve_after%0d: got en=%b fd=%b required en=0 fd=%b", j, in_en, frame_done, j == 15);
      end
      tick;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL starve_busy: got %b required 0", busy);
    end
`ifdef BCEDN_STREAM_STATS_EN
    checks++;
    if (starve_cnt !== 16'd46 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL starve_stats: got starve=%0d stall=%0d required 46/0", starve_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_excess;
    do_reset;
    prefill(16, 1);
    pulse_start;
    for (int k = 0; k < 16; k++) begin
      wr_en = (k >= 1 && k <= 4);
      wr_data = 8'(16 + k);
      tick;
      checks++;
      if (in_en !== 1'b1 || data_in !== 8'(k + 1)) begin
        errors++; $display("FAIL excess_word%0d: got en=%b data=%h required en=1 data=%h", k, in_en, data_in, 8'(k + 1));
      end
    end
    wr_en = 1'b0;
    tick;
    checks++;
    if (frame_done !== 1'b1 || overflow !== 1'b0 || wr_full !== 1'b0 || wr_afull !== 1'b0) begin
      errors++; $display("FAIL excess_done: got fd=%b ovf=%b full=%b afull=%b required 1 0 0 0", frame_done, overflow, wr_full, wr_afull);
    end
    pulse_start;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++;
      if (in_en !== 1'b1 || data_in !== 8'(17 + k)) begin
        errors++; $display("FAIL excess_rest%0d: got en=%b data=%h required en=1 data=%h", k, in_en, data_in, 8'(17 + k));
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++;
      if (in_en !== 1'b0 || busy !== 1'b1 || frame_done !== 1'b0) begin
        errors++; $display("FAIL excess_wait%0d: got en=%b busy=%b fd=%b required 0 1 0", k, in_en, busy, frame_done);
      end
    end
`ifdef BCEDN_STREAM_STATS_EN
    checks++;
    if (starve_cnt !== 16'd4) begin
      errors++; $display("FAIL excess_starve: got %0d required 4", starve_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid;
    int got;
    bit done;
    got = 0;
    done = 1'b0;
    do_reset;
    prefill(16, 1);
    pulse_start;
    for (int k = 0; k < 7; k++) begin
      tick;
      checks++;
      if (in_en !== 1'b1 || data_in !== 8'(k + 1)) begin
        errors++; $display("FAIL mid_word%0d: got en=%b data=%h required en=1 data=%h", k, in_en, data_in, 8'(k + 1));
      end
    end
    rst = 1'b0;
    tick;
    rst = 1'b1;
    checks++;
    if ({in_en, busy, frame_done, overflow, wr_full, wr_afull} !== 6'b0 || data_in !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: got flags=%b data=%h required 000000/00", {in_en, busy, frame_done, overflow, wr_full, wr_afull}, data_in);
    end
    pulse_start;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL mid_restart: got busy=%b required 1", busy);
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if (in_en !== 1'b0) begin
        errors++; $display("FAIL mid_empty%0d: got en=%b data=%h required en=0", k, in_en, data_in);
      end
    end
    for (int i = 0; i < 40 && !done; i++) begin
      wr_en = (i < 16);
      wr_data = 8'(8'h31 + i);
      tick;
      if (in_en) begin
        checks++;
        if (data_in !== 8'(8'h31 + got)) begin
          errors++; $display("FAIL mid_word_after%0d: got %h required %h", got, data_in, 8'(8'h31 + got));
        end
        got++;
      end
      if (frame_done) done = 1'b1;
    end
    wr_en = 1'b0;
    checks++;
    if (got != 16 || !done) begin
      errors++; $display("FAIL mid_complete: got words=%0d done=%b required 16/1", got, done);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_basic;
    test_pad_stall;
    test_overflow;
    test_starve;
    test_excess;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
